// File: rtl/sb_pkt_pkg.sv
// Shared types for the switchboard packet arbiter: destination width, arbiter
// FSM states and a beat-struct macro that takes the data width at the use site.
`ifndef SB_PKT_PKG_SV
`define SB_PKT_PKG_SV

`define SB_PKT_BEAT_T(dw) struct packed { \
  logic [(dw)-1:0]                  data; \
  logic [sb_pkt_pkg::SB_DEST_W-1:0] dest; \
  logic                             last; \
}

package sb_pkt_pkg;

  localparam int SB_DEST_W = 32;

  typedef enum logic {
    SB_ARB_IDLE   = 1'b0,
    SB_ARB_LOCKED = 1'b1
  } sb_arb_state_e;

  // Index width for n inputs; a single input still gets one bit.
  function automatic int sb_idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/sb_pkt_arbiter_if.sv
// Stream bundle between N switchboard sources, the arbiter and the queue-transmit
// stage. The master drives the inputs and out_ready; the slave is the arbiter.
interface sb_pkt_arbiter_if #(
  parameter int N  = 2,
  parameter int DW = 416
);
  import sb_pkt_pkg::*;

  logic [N*DW-1:0]        in_data;
  logic [N*SB_DEST_W-1:0] in_dest;
  logic [N-1:0]           in_last;
  logic [N-1:0]           in_valid;
  logic [N-1:0]           in_ready;
  logic [DW-1:0]          out_data;
  logic [SB_DEST_W-1:0]   out_dest;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_dest, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_dest, out_last, out_valid
  );

  modport slave (
    input  in_data, in_dest, in_last, in_valid, out_ready,
    output in_ready, out_data, out_dest, out_last, out_valid
  );
endinterface

// File: rtl/sb_pkt_fifo2.sv
// Two-entry FIFO holding whole beats; the head is read straight from a register
// so the output carries no combinational path from any input.
module sb_pkt_fifo2 #(
  parameter type beat_t = logic
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       push_i,
  input  beat_t      push_beat_i,
  input  logic       pop_i,
  output beat_t      head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_push;
  logic       do_pop;

  // A full buffer refuses a push even when the head leaves in the same cycle.
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/sb_pkt_arbiter.sv
// Packet-aware round-robin arbiter: a grant is held from the first beat of a
// packet to its last beat, and the merged stream passes through a 2-entry buffer.
module sb_pkt_arbiter
  import sb_pkt_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 416
) (
  input logic             clk,
  input logic             nreset,
  sb_pkt_arbiter_if.slave bus
);

  localparam int IW = sb_idx_w(N);

  typedef `SB_PKT_BEAT_T(DW) beat_t;

  sb_arb_state_e  state_q;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  rr_ptr_q;
  logic [IW-1:0]  rr_ptr_d;
  logic [IW-1:0]  winner;
  logic [IW-1:0]  sel;
  logic           any_valid;
  logic           space;
  logic           grant_en;
  logic           accept;
  logic           pop;
  logic           out_valid;
  logic [1:0]     count;
  beat_t          push_beat;
  beat_t          head_beat;

  function automatic logic [IW-1:0] rr_idx(logic [IW-1:0] base, int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk the search order backwards so the last hit is the first valid
  // input at or after rr_ptr.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.in_valid[rr_idx(rr_ptr_q, k)]) begin
        winner    = rr_idx(rr_ptr_q, k);
        any_valid = 1'b1;
      end
    end
  end

  assign sel      = (state_q == SB_ARB_LOCKED) ? grant_q : winner;
  assign space    = (count != 2'd2);
  // While locked the granted input keeps its ready even if it drops valid.
  assign grant_en = nreset && space && ((state_q == SB_ARB_LOCKED) || any_valid);

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.in_ready[gi] = grant_en && (sel == IW'(gi));
  end

  assign accept         = |(bus.in_ready & bus.in_valid);
  assign push_beat.data = bus.in_data[int'(sel)*DW +: DW];
  assign push_beat.dest = bus.in_dest[int'(sel)*SB_DEST_W +: SB_DEST_W];
  assign push_beat.last = bus.in_last[sel];
  assign rr_ptr_d       = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= SB_ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      if (push_beat.last) begin
        state_q  <= SB_ARB_IDLE;
        rr_ptr_q <= rr_ptr_d;
      end else begin
        state_q <= SB_ARB_LOCKED;
        grant_q <= sel;
      end
    end
  end

  assign pop = out_valid && bus.out_ready;

  sb_pkt_fifo2 #(
    .beat_t (beat_t)
  ) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (accept),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .head_o      (head_beat),
    .valid_o     (out_valid),
    .count_o     (count)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_beat.data;
  assign bus.out_dest  = head_beat.dest;
  assign bus.out_last  = head_beat.last;

endmodule

// File: tb/tb_sb_pkt_arbiter.sv
// Randomised bench for sb_pkt_arbiter: per-input packet queues feed the DUT and
// a queue-based model of the arbitration and buffering rules predicts every cycle.
module tb_sb_pkt_arbiter;
  import sb_pkt_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
    int            src;
  } tbeat_t;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  always #5 clk = ~clk;

  sb_pkt_arbiter_if #(.N(N), .DW(DW)) bus ();

  sb_pkt_arbiter #(.N(N), .DW(DW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  tbeat_t src_q [N][$];
  tbeat_t mdl_q [$];
  tbeat_t out_log [$];
  int     lock;
  int     rr;
  int     vp [N];
  int     rdy_pct;
  int     seq;
  int     n_checks;
  int     n_errors;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_beat(int i, logic [DW-1:0] data, logic [31:0] dest, logic last);
    tbeat_t b;
    b.data = data;
    b.dest = dest;
    b.last = last;
    b.src  = i;
    src_q[i].push_back(b);
  endtask

  task automatic load_pkt(int i, int len);
    logic [31:0] dest;
    dest = $urandom;
    for (int b = 0; b < len; b++) begin
      add_beat(i, {8'(i), 24'(seq), 32'($urandom)}, dest, b == len - 1);
      seq++;
    end
  endtask

  // Which input the rules say must be ready this cycle, given offered valids.
  function automatic logic [N-1:0] model_ready(logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (mdl_q.size() < 2) begin
      if (lock >= 0) begin
        r[lock] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (v[(rr + k) % N]) begin
            r[(rr + k) % N] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic         rdy;
    tbeat_t       b;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      v[i] = (src_q[i].size() > 0) && ($urandom_range(99) < vp[i]);
      bus.in_valid[i] = v[i];
      if (src_q[i].size() > 0) begin
        bus.in_data[i*DW +: DW] = src_q[i][0].data;
        bus.in_dest[i*32 +: 32] = src_q[i][0].dest;
        bus.in_last[i]          = src_q[i][0].last;
      end else begin
        bus.in_data[i*DW +: DW] = {$urandom, $urandom};
        bus.in_dest[i*32 +: 32] = $urandom;
        bus.in_last[i]          = 1'($urandom);
      end
    end
    rdy = ($urandom_range(99) < rdy_pct);
    bus.out_ready = rdy;
    #1;
    exp_rdy = model_ready(v);
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(bus.out_valid), 64'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) begin
      check_eq("out_data", bus.out_data, mdl_q[0].data);
      check_eq("out_dest", 64'(bus.out_dest), 64'(mdl_q[0].dest));
      check_eq("out_last", 64'(bus.out_last), 64'(mdl_q[0].last));
    end
    if (mdl_q.size() != 0 && rdy) out_log.push_back(mdl_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i] && v[i]) begin
        b = src_q[i].pop_front();
        mdl_q.push_back(b);
        if (b.last) begin
          lock = -1;
          rr   = (i + 1) % N;
        end else begin
          lock = i;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_out_data", bus.out_data, 64'd0);
    check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
    repeat (2) @(negedge clk);
    bus.in_valid = '0;
    nreset = 1'b1;
    mdl_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    lock = -1;
    rr   = 0;
  endtask

  task automatic check_drained(string tag);
    int left;
    left = mdl_q.size();
    for (int i = 0; i < N; i++) left += src_q[i].size();
    check_eq(tag, 64'(left), 64'd0);
  endtask

  initial begin
    logic [63:0] exp1_data [4];
    logic        exp1_last [4];
    int          total;
    exp1_data = '{64'd1, 64'd2, 64'd3, 64'd9};
    exp1_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    n_checks = 0;
    n_errors = 0;
    seq = 0;
    lock = -1;
    rr = 0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) vp[i] = 100;
    rdy_pct = 100;

    // Directed two-packet merge: 3-beat packet on in0, single beat on in1.
    do_reset();
    add_beat(0, 64'd1, 32'h10, 1'b0);
    add_beat(0, 64'd2, 32'h10, 1'b0);
    add_beat(0, 64'd3, 32'h10, 1'b1);
    add_beat(1, 64'd9, 32'h20, 1'b1);
    out_log.delete();
    repeat (8) step();
    check_eq("t1_count", 64'(out_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < out_log.size(); k++) begin
      check_eq("t1_data", out_log[k].data, exp1_data[k]);
      check_eq("t1_last", 64'(out_log[k].last), 64'(exp1_last[k]));
    end

    // Fairness with every input holding single-beat packets.
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) load_pkt(i, 1);
    out_log.delete();
    repeat (12) step();
    check_eq("t2_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < out_log.size(); k++) check_eq("t2_order", 64'(out_log[k].src), 64'(k % N));

    // Backpressure: output stalled 5 cycles during a 4-beat packet.
    load_pkt(2, 4);
    out_log.delete();
    rdy_pct = 0;
    repeat (5) step();
    rdy_pct = 100;
    repeat (6) step();
    check_eq("t3_count", 64'(out_log.size()), 64'd4);
    check_drained("t3_drain");

    // Granted input drops valid mid-packet while in1 waits.
    load_pkt(0, 4);
    load_pkt(1, 1);
    out_log.delete();
    repeat (2) step();
    vp[0] = 0;
    repeat (3) step();
    vp[0] = 100;
    repeat (6) step();
    check_eq("t4_count", 64'(out_log.size()), 64'd5);
    for (int k = 0; k < out_log.size(); k++) check_eq("t4_src", 64'(out_log[k].src), (k < 4) ? 64'd0 : 64'd1);

    // Reset while locked with a full buffer, then only in1 offers.
    do_reset();
    load_pkt(0, 5);
    rdy_pct = 0;
    repeat (3) step();
    do_reset();
    rdy_pct = 100;
    load_pkt(1, 1);
    out_log.delete();
    repeat (4) step();
    check_eq("t5_count", 64'(out_log.size()), 64'd1);
    if (out_log.size() > 0) check_eq("t5_src", 64'(out_log[0].src), 64'd1);

    // Streaming at one beat per cycle across random packets.
    do_reset();
    total = 0;
    while (total < 100) begin
      int len;
      len = $urandom_range(1, 4);
      load_pkt($urandom_range(N - 1), len);
      total += len;
    end
    out_log.delete();
    repeat (total + 3) step();
    check_eq("t6_count", 64'(out_log.size()), 64'(total));
    check_drained("t6_drain");

    // Mixed random valid and ready.
    for (int p = 0; p < 20; p++) load_pkt($urandom_range(N - 1), $urandom_range(1, 5));
    for (int i = 0; i < N; i++) vp[i] = 60;
    rdy_pct = 50;
    repeat (500) step();
    check_drained("t7_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
